// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and key codes for the calculator operand entry path
package calc_pkg;

  typedef enum logic [2:0] {
    ENTRY_A,
    LOAD_A,
    ENTRY_B,
    LOAD_B,
    DONE
  } entry_state_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam int         MAX_DIGITS = 3;

endpackage

// File: rtl/dec_accum.sv
// rtl/dec_accum.sv - decimal digit accumulator with range and digit-count limits
module dec_accum #(
  parameter int MAX_DIGITS = calc_pkg::MAX_DIGITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_en,
  input  logic [3:0] digit,
  input  logic       clear,
  output logic [7:0] acc,
  output logic [1:0] count
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  logic [9:0] next_val;
  logic       accept;

  // count < MAX_DIGITS bounds acc to 99 here, so acc*10+9 fits in 10 bits
  assign next_val = ({2'b00, acc} * 10'd10) + {6'b000000, digit};
  assign accept   = digit_en && (count < MAX_CNT) && (next_val <= 10'd255);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      acc   <= 8'd0;
      count <= 2'd0;
    end else if (accept) begin
      acc   <= next_val[7:0];
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/operand_entry_ctrl.sv
// rtl/operand_entry_ctrl.sv - sequences keypad entry of operands A then B into the operand registers
module operand_entry_ctrl #(
  parameter logic [3:0] KEY_ENTER  = calc_pkg::KEY_ENTER,
  parameter logic [3:0] KEY_CLEAR  = calc_pkg::KEY_CLEAR,
  parameter int         MAX_DIGITS = calc_pkg::MAX_DIGITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] num,
  output logic       load_a,
  output logic       load_b,
  output logic       entry_b,
  output logic       operands_ready,
  output logic [7:0] disp_value,
  output logic [1:0] digit_count
);

  import calc_pkg::*;

  entry_state_t state;
  logic [7:0]   acc;
  logic [1:0]   count;
  logic         in_entry;
  logic         is_digit;
  logic         enter_key;
  logic         clear_key;
  logic         digit_en;
  logic         acc_clear;

  assign in_entry  = (state == ENTRY_A) || (state == ENTRY_B);
  assign is_digit  = key_valid && (key_code <= 4'd9);
  assign enter_key = key_valid && (key_code == KEY_ENTER);
  assign clear_key = key_valid && (key_code == KEY_CLEAR);
  assign digit_en  = in_entry && is_digit;

  // LOAD states wipe the accumulator so the next entry starts from zero
  assign acc_clear = (state == LOAD_A) || (state == LOAD_B) ||
                     (clear_key && (in_entry || (state == DONE)));

  dec_accum #(
    .MAX_DIGITS(MAX_DIGITS)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .digit_en (digit_en),
    .digit    (key_code),
    .clear    (acc_clear),
    .acc      (acc),
    .count    (count)
  );

  assign disp_value  = acc;
  assign digit_count = count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ENTRY_A;
      num            <= 8'd0;
      load_a         <= 1'b0;
      load_b         <= 1'b0;
      entry_b        <= 1'b0;
      operands_ready <= 1'b0;
    end else begin
      load_a <= 1'b0;
      load_b <= 1'b0;
      case (state)
        ENTRY_A: begin
          if (enter_key && (count != 2'd0)) begin
            num    <= acc;
            load_a <= 1'b1;
            state  <= LOAD_A;
          end
        end
        LOAD_A: begin
          entry_b <= 1'b1;
          state   <= ENTRY_B;
        end
        ENTRY_B: begin
          if (enter_key && (count != 2'd0)) begin
            num    <= acc;
            load_b <= 1'b1;
            state  <= LOAD_B;
          end
        end
        LOAD_B: begin
          operands_ready <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (clear_key) begin
            entry_b        <= 1'b0;
            operands_ready <= 1'b0;
            state          <= ENTRY_A;
          end
        end
        default: state <= ENTRY_A;
      endcase
    end
  end

endmodule
